// File: rtl/fifo_pkg.sv
// Shared constants and types for the synchronous FIFO and its read-side stream adapter.
package fifo_pkg;
  localparam int FIFO_DATA_W     = 8;
  localparam int BEAT_COUNT_W    = 16;
  localparam int FIFO_RD_LATENCY = 1;
  // One slot per word that can be in flight behind a held head word.
  localparam int BUF_DEPTH       = FIFO_RD_LATENCY + 1;

  typedef logic [FIFO_DATA_W-1:0] fifo_word_t;
endpackage

// File: rtl/fifo_stream_adapter_if.sv
// FIFO read port plus valid/ready stream and status; master = adapter side.
interface fifo_stream_adapter_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) ();
  logic [DATA_WIDTH-1:0]  data_in;
  logic                   empty;
  logic                   rd_en;
  logic                   m_valid;
  logic [DATA_WIDTH-1:0]  m_data;
  logic                   m_ready;
  logic [COUNT_WIDTH-1:0] beat_count;
  logic                   idle;

  modport master (
    input  data_in, empty, m_ready,
    output rd_en, m_valid, m_data, beat_count, idle
  );
  modport slave (
    output data_in, empty, m_ready,
    input  rd_en, m_valid, m_data, beat_count, idle
  );
endinterface

// File: rtl/stream_skid_buf.sv
// 2-entry circular output buffer; push at tail, pop at head, both in one cycle allowed.
module stream_skid_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            occ
);
  logic [1:0][DATA_WIDTH-1:0] mem_q, mem_d;
  logic                       head_q, head_d;
  logic                       tail_q, tail_d;
  logic [1:0]                 occ_q, occ_d;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    if (push) begin
      mem_d[tail_q] = push_data;
      tail_d        = ~tail_q;
    end
    if (pop) head_d = ~head_q;
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign head_data = mem_q[head_q];
  assign occ       = occ_q;
endmodule

// File: rtl/fifo_stream_adapter.sv
// Drains a 1-cycle-latency FIFO read port into a full-throughput valid/ready stream.
module fifo_stream_adapter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = FIFO_DATA_W,
  parameter int COUNT_WIDTH = BEAT_COUNT_W
) (
  input logic                  clk,
  input logic                  rst_n,
  fifo_stream_adapter_if.master bus
);
  logic                   inflight_q, inflight_d;
  logic [COUNT_WIDTH-1:0] beat_count_q, beat_count_d;
  logic [1:0]             occ, level;
  logic [DATA_WIDTH-1:0]  head_data;
  logic                   m_valid, pop, rd_en;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && bus.m_ready;

  // Slots committed after this edge; counting the pop lets a read issue in the
  // same cycle a word leaves, which is what sustains one beat per cycle.
  always_comb begin
    level        = occ + {1'b0, inflight_q} - {1'b0, pop};
    rd_en        = rst_n && !bus.empty && (level < 2'(BUF_DEPTH));
    inflight_d   = rd_en;
    beat_count_d = beat_count_q + COUNT_WIDTH'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q   <= 1'b0;
      beat_count_q <= '0;
    end else begin
      inflight_q   <= inflight_d;
      beat_count_q <= beat_count_d;
    end
  end

  stream_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (bus.data_in),
    .pop       (pop),
    .head_data (head_data),
    .occ       (occ)
  );

  assign bus.rd_en      = rd_en;
  assign bus.m_valid    = m_valid;
  assign bus.m_data     = head_data;
  assign bus.beat_count = beat_count_q;
  assign bus.idle       = (occ == 2'd0) && !inflight_q && bus.empty;
endmodule
